// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with a registered read port: pointers, occupancy and status.
// Define RAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module ram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
`ifdef RAM_FIFO_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              dout_valid_q;
    logic              push_ok, pop_ok;

    // Acceptance uses the registered flags, so full&push&pop favours the pop and empty&push&pop the push.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= (count_d == DEPTH);
            empty_q      <= (count_d == '0);
            dout_valid_q <= pop_ok;
        end
    end

`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && full_q)  overflow_q  <= 1'b1;
            if (pop && empty_q)  underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign ram_we      = push_ok;
    assign ram_wr_addr = wr_ptr_q;
    assign ram_din     = din;
    assign ram_re      = pop_ok;
    assign ram_rd_addr = rd_ptr_q;
    // The RAM registers its read, so its output lines up with dout_valid.
    assign dout        = ram_dout;
    assign dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 16x8 registered-read RAM attached.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop;
    logic [7:0] din;
    logic       full, empty, dout_valid;
    logic [4:0] count;
    logic       ram_we, ram_re;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_din, ram_dout, dout;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
        .full(full), .empty(empty), .count(count),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout),
        .dout(dout), .dout_valid(dout_valid)
`ifdef RAM_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    // External RAM stand-in: synchronous write, registered read.
    logic [7:0] mem [16];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_din;
        if (ram_re) rd_q <= mem[ram_rd_addr];
    end
    assign ram_dout = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every dout_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dout_unexpected actual=%0h expected=none at %0t", dout, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("dout", {24'd0, dout}, {24'd0, e});
                $display("pop data %0h expected %0h", dout, e);
            end
        end
    end

    // Drive one cycle from a negedge; check RAM strobes before the posedge, return at next negedge.
    task automatic step(input bit p, input logic [7:0] d, input bit q,
                        input bit exp_we, input bit exp_re, input logic [7:0] exp_data);
        push = p; din = d; pop = q;
        #1;
        chk("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
        chk("ram_re", {31'd0, ram_re}, {31'd0, exp_re});
        if (exp_re) exp_q.push_back(exp_data);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; din = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic [4:0] c, input bit f, input bit e);
        chk({tag, "_count"}, {27'd0, count}, {27'd0, c});
        chk({tag, "_full"},  {31'd0, full},  {31'd0, f});
        chk({tag, "_empty"}, {31'd0, empty}, {31'd0, e});
    endtask

    initial begin
        logic [7:0] v3[3];
        v3[0] = 8'hA5; v3[1] = 8'h3C; v3[2] = 8'h7E;
        rst = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;

        // 1: reset and idle
        idle(3);
        chk_status("reset", 5'd0, 1'b0, 1'b1);
        chk("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("reset_ram_we", {31'd0, ram_we}, 32'd0);
        chk("reset_ram_re", {31'd0, ram_re}, 32'd0);
`ifdef RAM_FIFO_ERR_FLAGS_EN
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_underflow", {31'd0, underflow}, 32'd0);
`endif
        rst = 1'b1;
        idle(2);
        chk_status("idle", 5'd0, 1'b0, 1'b1);

        // 2: three words through
        for (int i = 0; i < 3; i++) step(1'b1, v3[i], 1'b0, 1'b1, 1'b0, 8'h00);
        chk_status("t2_filled", 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, v3[i]);
        idle(1);
        chk_status("t2_drained", 5'd0, 1'b0, 1'b1);
        chk("t2_queue_empty", exp_q.size(), 32'd0);
`ifdef RAM_FIFO_ERR_FLAGS_EN
        chk("t2_overflow", {31'd0, overflow}, 32'd0);
`endif

        // 3: fill to 16, then a dropped 17th push
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 8'h00);
        chk_status("t3_full", 5'd16, 1'b1, 1'b0);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_status("t3_drop", 5'd16, 1'b1, 1'b0);
`ifdef RAM_FIFO_ERR_FLAGS_EN
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
`endif

        // 4: push+pop at full, drain, then push+pop at empty
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00);
        chk_status("t4_full_pp", 5'd15, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(i));
        idle(1);
        chk_status("t4_drained", 5'd0, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00);
        chk_status("t4_empty_pp", 5'd1, 1'b0, 1'b0);
        chk("t4_no_valid", {31'd0, dout_valid}, 32'd0);
`ifdef RAM_FIFO_ERR_FLAGS_EN
        chk("t4_underflow", {31'd0, underflow}, 32'd1);
`endif

        // 5: 20 streaming push/pop pairs with one word resident
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h80 + 8'(i), 1'b1, 1'b1, 1'b1, (i == 0) ? 8'h11 : 8'h80 + 8'(i - 1));
            chk("t5_count", {27'd0, count}, 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h93);
        idle(1);
        chk_status("t5_drained", 5'd0, 1'b0, 1'b1);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // 6: reset mid-stream with a pop in flight
        for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1, 1'b0, 8'h00);
        chk_status("t6_pre", 5'd5, 1'b0, 1'b0);
        pop = 1'b1;
        #1;
        chk("t6_ram_re", {31'd0, ram_re}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        pop = 1'b0;
        #1;
        exp_q.delete();
        chk_status("t6_rst", 5'd0, 1'b0, 1'b1);
        chk("t6_dout_valid", {31'd0, dout_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42);
        idle(1);
        chk_status("t6_post", 5'd0, 1'b0, 1'b1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
